// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word memory responder for the L1 cache's lower-level port.
// Define MEM_RESPONDER_PROTOCOL_CHECK_EN to build the sticky o_protocol_err checker.
module mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 4096,
    parameter int LATENCY    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_mem_read_en,
    input  logic                  i_mem_write_en,
    input  logic [ADDR_WIDTH-1:0] i_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_write_data,
    output logic [DATA_WIDTH-1:0] o_mem_read_data,
    output logic                  o_mem_data_valid,
    output logic                  o_protocol_err
);
    localparam int OFF = $clog2(DATA_WIDTH / 8);
    localparam int IDX = $clog2(MEM_DEPTH);
    localparam int CW  = LATENCY > 1 ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [IDX-1:0]        idx;
    logic                  is_read;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [IDX-1:0]        addr_idx;
    logic                  unused_ok;

    assign addr_idx  = i_mem_addr[OFF+IDX-1:OFF];
    assign unused_ok = ^i_mem_addr;

    // Storage is deliberately outside the reset domain so contents survive i_rst.
    always_ff @(posedge i_clk)
        if (state == IDLE && i_mem_write_en) mem[addr_idx] <= i_mem_write_data;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            state            <= IDLE;
            cnt              <= '0;
            idx              <= '0;
            is_read          <= 1'b0;
            o_mem_data_valid <= 1'b0;
            o_mem_read_data  <= '0;
        end else begin
            o_mem_data_valid <= 1'b0;
            case (state)
                IDLE: if (i_mem_write_en || i_mem_read_en) begin
                    state   <= WAIT;
                    cnt     <= CNT_INIT;
                    idx     <= addr_idx;
                    is_read <= !i_mem_write_en;
                end
                WAIT: if (cnt == '0) begin
                    state            <= RESPOND;
                    o_mem_data_valid <= 1'b1;
                    if (is_read) o_mem_read_data <= mem[idx];
                end else cnt <= cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end

`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  err;

    // acc_addr tracks the bus while idle, so in WAIT it holds the accepted address.
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            acc_addr <= '0;
            err      <= 1'b0;
        end else begin
            if (state == IDLE) acc_addr <= i_mem_addr;
            if ((i_mem_read_en && i_mem_write_en) ||
                (state == WAIT && ((is_read ? !i_mem_read_en : !i_mem_write_en) ||
                                   i_mem_addr != acc_addr)))
                err <= 1'b1;
        end

    assign o_protocol_err = err;
`else
    assign o_protocol_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and randomized checks of mem_responder against a word-array model.
module tb_mem_responder;
`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rd, wr, v, err, rd1, wr1, v1, err1;
    logic [31:0] a, wd, rdata, a1, wd1, rdata1;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model [int];
    int          keys[$];
    int          pulses[$];
    logic [31:0] last_rd;
    logic        exp_err;
    bit          seen;
    int          n, op, k;
    logic [31:0] ad, dt;

    mem_responder u_dut (
        .i_clk(clk), .i_rst(rst), .i_mem_read_en(rd), .i_mem_write_en(wr),
        .i_mem_addr(a), .i_mem_write_data(wd), .o_mem_read_data(rdata),
        .o_mem_data_valid(v), .o_protocol_err(err)
    );

    mem_responder #(.LATENCY(1), .MEM_DEPTH(16)) u_l1 (
        .i_clk(clk), .i_rst(rst), .i_mem_read_en(rd1), .i_mem_write_en(wr1),
        .i_mem_addr(a1), .i_mem_write_data(wd1), .o_mem_read_data(rdata1),
        .o_mem_data_valid(v1), .o_protocol_err(err1)
    );

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 2) & 32'hFFF);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request on the LATENCY=4 instance; optionally move the address once WAIT begins.
    task automatic txn(input bit r, input bit w, input logic [31:0] addr, input logic [31:0] data,
                       input bit chg, input logic [31:0] alt, input string tag);
        int cyc;
        @(negedge clk);
        rd = r; wr = w; a = addr; wd = data;
        if (r && w) exp_err = exp_err | CHK;
        @(negedge clk);
        cyc = 1;
        if (chg) begin
            a = alt;
            exp_err = exp_err | CHK;
            @(negedge clk);
            cyc++;
            chk({tag, " err rise"}, err, exp_err);
        end
        while (!v && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        rd = 1'b0; wr = 1'b0;
        chk({tag, " latency"}, cyc, 5);
        if (w) begin
            if (!model.exists(widx(addr))) keys.push_back(widx(addr));
            model[widx(addr)] = data;
        end else last_rd = model[widx(addr)];
        chk({tag, " data"}, rdata, last_rd);
        @(negedge clk);
        chk({tag, " pulse width"}, v, 0);
        chk({tag, " err"}, err, exp_err);
    endtask

    initial begin
        rd = 0; wr = 0; a = 0; wd = 0; rd1 = 0; wr1 = 0; a1 = 0; wd1 = 0;
        exp_err = 1'b0;
        last_rd = '0;
        repeat (2) @(negedge clk);
        chk("reset valid", v, 0);
        chk("reset rdata", rdata, 0);
        chk("reset err", err, 0);
        chk("reset l1 valid", v1, 0);
        rst = 1'b0;

        txn(0, 1, 32'h40, 32'hDEADBEEF, 0, 0, "wr 0x40");
        txn(1, 0, 32'h40, 0, 0, 0, "rd 0x40");
        txn(0, 1, 32'h0, 32'h11, 0, 0, "wr 0x0");
        txn(0, 1, 32'h3FFC, 32'h22, 0, 0, "wr 0x3ffc");
        txn(1, 0, 32'h4000, 0, 0, 0, "rd alias 0x4000");
        txn(1, 0, 32'h3FFE, 0, 0, 0, "rd offset 0x3ffe");
        txn(1, 1, 32'h80, 32'h55, 0, 0, "rd+wr 0x80");
        txn(1, 0, 32'h80, 0, 0, 0, "rd 0x80");
        txn(1, 0, 32'h0, 0, 1, 32'h3FFC, "addr change");

        // Reset in the middle of a read's WAIT phase.
        @(negedge clk);
        rd = 1'b1; a = 32'h40;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid-rst valid", v, 0);
        chk("mid-rst rdata", rdata, 0);
        chk("mid-rst err", err, 0);
        rd = 1'b0;
        exp_err = 1'b0;
        last_rd = '0;
        seen = 1'b0;
        repeat (3) begin @(negedge clk); seen |= v; end
        rst = 1'b0;
        repeat (8) begin @(negedge clk); seen |= v; end
        chk("mid-rst no pulse", seen, 0);
        txn(1, 0, 32'h40, 0, 0, 0, "post-rst rd 0x40");

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            dt = $urandom;
            if (op == 1 || op == 2) k = keys[$urandom_range(0, keys.size() - 1)];
            else k = $urandom_range(0, 4095);
            ad = ($urandom << 14) | (k << 2) | $urandom_range(0, 3);
            txn(op != 0, op == 0 || op == 3, ad, dt, 0, 0, $sformatf("rand%0d", i));
        end

        // LATENCY=1 instance: read held continuously must re-accept every 3 cycles.
        @(negedge clk);
        wr1 = 1'b1; a1 = 32'h8; wd1 = 32'hA5;
        n = 0;
        do begin @(negedge clk); n++; end while (!v1 && n < 8);
        wr1 = 1'b0;
        chk("l1 wr latency", n, 2);
        @(negedge clk);
        rd1 = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (v1) begin
                pulses.push_back(c);
                chk("l1 rd data", rdata1, 32'hA5);
            end
        end
        rd1 = 1'b0;
        chk("l1 pulse count", pulses.size(), 5);
        foreach (pulses[j]) chk("l1 pulse cycle", pulses[j], 2 + 3 * j);
        chk("l1 err", err1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
